// File: rtl/string_avalon_master.sv
// string_avalon_master
//   Avalon-MM master that sequences one String HW Accelerator operation per
//   command: it writes A, B and the control word with go set, then polls the
//   control register until done is seen, reads the result, clears go, and
//   presents the result on the response port.
//
//   Optional build macro: STRING_MASTER_TIMEOUT_EN
//     When defined, polling is bounded by TIMEOUT_CYCLES. On expiry the
//     master still clears go, and it returns 32'hFFFF_FFFF with o_rsp_error=1.
//     When undefined, polling is unbounded and o_rsp_error stays 0.
//
//   Parameters
//     READ_LATENCY   cycles from read strobe to valid slave readdata (1..4)
//     POLL_GAP       idle cycles between control-register polls (0..15)
//     TIMEOUT_CYCLES poll budget in cycles (timeout build only)
//
//   Ports
//     i_clk, i_reset          clock, synchronous active-low reset
//     i_cmd_valid/o_cmd_ready command handshake (ready only while idle)
//     i_cmd_index/length/a/b  operation index, length field, string A, string B
//     o_rsp_valid/i_rsp_ready response handshake
//     o_rsp_data, o_rsp_error result word, timeout flag
//     o_address, o_chipselect, o_write, o_read, o_writedata, i_readdata
//                             Avalon-MM master port (all outputs registered)
module string_avalon_master #(
  parameter int READ_LATENCY   = 1,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_index,
  input  logic [2:0]  i_cmd_length,
  input  logic [31:0] i_cmd_a,
  input  logic [31:0] i_cmd_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_error,
  output logic [2:0]  o_address,
  output logic        o_chipselect,
  output logic        o_write,
  output logic        o_read,
  output logic [31:0] o_writedata,
  input  logic [31:0] i_readdata
);

`ifdef STRING_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [2:0] ADDR_A    = 3'd0;
  localparam logic [2:0] ADDR_B    = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_RES  = 3'd3;

  // Cycle index (within a wait state) at which readdata is valid, and the
  // index at which the post-poll gap is over.
  localparam logic [4:0]  RD_LAST  = 5'(READ_LATENCY - 1);
  localparam logic [4:0]  GAP_LAST = 5'(READ_LATENCY - 1 + POLL_GAP);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL_RD, S_POLL_WAIT,
    S_RES_RD, S_RES_WAIT, S_CLR_GO, S_RESP
  } state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_wcnt;
  logic [31:0] r_tcnt;
  logic [2:0]  r_idx, r_len;
  logic [31:0] r_b;
  logic        r_cmd_ready, r_rsp_valid, r_rsp_error;
  logic [31:0] r_rsp_data;
  logic [2:0]  r_address;
  logic        r_chipselect, r_write, r_read;
  logic [31:0] r_writedata;

  logic        w_accept, w_done, w_tmo, w_rd_due;
  logic        w_write, w_read;
  logic [2:0]  w_addr;
  logic [31:0] w_wdata;

  assign w_accept = (r_state == S_IDLE) && r_cmd_ready && i_cmd_valid;
  assign w_rd_due = (r_wcnt == RD_LAST);

  // Next state plus the Avalon signals for the state being entered; those
  // are registered so each strobe lines up with its state.
  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_tmo   = 1'b0;
    w_write = 1'b0;
    w_read  = 1'b0;
    w_addr  = 3'd0;
    w_wdata = 32'd0;

    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_WR_A;
      S_WR_A:    w_next = S_WR_B;
      S_WR_B:    w_next = S_WR_GO;
      S_WR_GO:   w_next = S_POLL_RD;
      S_POLL_RD: w_next = S_POLL_WAIT;
      S_POLL_WAIT: begin
        // readdata is only meaningful on the due cycle; after that we are
        // just spacing out the polls.
        if (w_rd_due && i_readdata[0]) begin
          w_done = 1'b1;
          w_next = S_RES_RD;
        end else if (r_wcnt >= GAP_LAST) begin
          w_next = S_POLL_RD;
        end
      end
      S_RES_RD:   w_next = S_RES_WAIT;
      S_RES_WAIT: if (w_rd_due) w_next = S_CLR_GO;
      S_CLR_GO:   w_next = S_RESP;
      S_RESP:     if (i_rsp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase

    // A done seen on the same cycle wins over the timeout.
    if (TMO_EN && (r_state == S_POLL_RD || r_state == S_POLL_WAIT) &&
        !w_done && (r_tcnt >= TMO_LAST)) begin
      w_tmo  = 1'b1;
      w_next = S_CLR_GO;
    end

    case (w_next)
      S_WR_A: begin
        // Only reachable from IDLE, so A goes straight from the port.
        w_write = 1'b1;
        w_addr  = ADDR_A;
        w_wdata = i_cmd_a;
      end
      S_WR_B: begin
        w_write = 1'b1;
        w_addr  = ADDR_B;
        w_wdata = r_b;
      end
      S_WR_GO: begin
        w_write = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = {24'd0, r_len, r_idx, 2'b10};
      end
      S_POLL_RD: begin
        w_read = 1'b1;
        w_addr = ADDR_CTRL;
      end
      S_RES_RD: begin
        w_read = 1'b1;
        w_addr = ADDR_RES;
      end
      S_CLR_GO: begin
        w_write = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = {24'd0, r_len, r_idx, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= 5'd0;
      r_tcnt       <= 32'd0;
      r_idx        <= 3'd0;
      r_len        <= 3'd0;
      r_b          <= 32'd0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 1'b0;
      r_rsp_data   <= 32'd0;
      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_writedata  <= 32'd0;
    end else begin
      r_state <= w_next;

      // Restarts on every state change, saturates instead of wrapping.
      if (w_next != r_state)   r_wcnt <= 5'd0;
      else if (r_wcnt != '1)   r_wcnt <= r_wcnt + 5'd1;

      if (r_state == S_WR_GO)
        r_tcnt <= 32'd0;
      else if ((r_state == S_POLL_RD || r_state == S_POLL_WAIT) && r_tcnt != '1)
        r_tcnt <= r_tcnt + 32'd1;

      if (w_accept) begin
        r_idx       <= i_cmd_index;
        r_len       <= i_cmd_length;
        r_b         <= i_cmd_b;
        r_rsp_error <= 1'b0;
      end

      if (r_state == S_RES_WAIT && w_rd_due)
        r_rsp_data <= i_readdata;

      if (w_tmo) begin
        r_rsp_data  <= 32'hFFFF_FFFF;
        r_rsp_error <= 1'b1;
      end

      r_cmd_ready  <= (w_next == S_IDLE);
      r_rsp_valid  <= (w_next == S_RESP);
      r_address    <= w_addr;
      r_chipselect <= w_write | w_read;
      r_write      <= w_write;
      r_read       <= w_read;
      r_writedata  <= w_wdata;
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_error  = r_rsp_error;
  assign o_address    = r_address;
  assign o_chipselect = r_chipselect;
  assign o_write      = r_write;
  assign o_read       = r_read;
  assign o_writedata  = r_writedata;

endmodule

// File: tb/tb_string_avalon_master.sv
// Directed bench for string_avalon_master with a behavioural accelerator
// slave (register file, done after a programmable number of polls, result
// preset per test) and a log of every Avalon transaction.
module tb_string_avalon_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_index, cmd_length;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_data;
  logic [2:0]  address;
  logic        chipselect, write, read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  string_avalon_master #(
    .READ_LATENCY(1), .POLL_GAP(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_index(cmd_index), .i_cmd_length(cmd_length),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_error(rsp_error),
    .o_address(address), .o_chipselect(chipselect),
    .o_write(write), .o_read(read),
    .o_writedata(writedata), .i_readdata(readdata)
  );

  // ---- slave model (read latency 1) ----
  logic [31:0] s_a = '0, s_b = '0, s_ctrl = '0, s_rdata = '0, s_res = '0;
  int s_polls = 0;
  int s_base  = 0;
  int s_need  = 1;

  assign readdata = s_rdata;

  always @(posedge clk) begin
    if (chipselect && write) begin
      case (address)
        3'd0:    s_a    <= writedata;
        3'd1:    s_b    <= writedata;
        3'd2:    s_ctrl <= writedata;
        default: ;
      endcase
    end
    if (chipselect && read) begin
      if (address == 3'd2) begin
        s_polls <= s_polls + 1;
        s_rdata <= {s_ctrl[31:1], (s_polls + 1 - s_base >= s_need)};
      end else if (address == 3'd3) begin
        s_rdata <= s_res;
      end else begin
        s_rdata <= 32'hDEAD_BEEF;
      end
    end
  end

  // ---- bus log: {write, address, data-if-write} ----
  logic [35:0] bus_log [0:1023];
  int bus_n = 0;
  int cs_bad = 0;

  always @(posedge clk) begin
    if (rst_n && chipselect && bus_n < 1024) begin
      bus_log[bus_n] <= {write, address, write ? writedata : 32'd0};
      bus_n <= bus_n + 1;
    end
  end

  always @(negedge clk)
    if (chipselect !== (write | read)) cs_bad <= cs_bad + 1;

  function automatic logic [35:0] bw(input logic [2:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [35:0] br(input logic [2:0] a);
    return {1'b0, a, 32'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a command and return right after the accepting edge.
  task automatic start_cmd(input logic [2:0] idx, input logic [2:0] len,
                           input logic [31:0] a, input logic [31:0] b);
    int n;
    cmd_index = idx; cmd_length = len; cmd_a = a; cmd_b = b;
    cmd_valid = 1'b1;
    s_base = s_polls;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("cmd_ready_seen", {35'd0, cmd_ready}, 36'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycles from the accepting edge to rsp_valid.
  task automatic wait_rsp(output int lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    lat = n;
    chk("rsp_valid_seen", {35'd0, rsp_valid}, 36'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, mark, bad_v, bad_d, bad_b, bad_r, seen;
    logic [31:0] held;
    logic [35:0] exp1 [8];

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_index = '0; cmd_length = '0; cmd_a = '0; cmd_b = '0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_cmd_ready", {35'd0, cmd_ready}, 36'd0);
    chk("rst_rsp", {2'b0, rsp_valid, rsp_error, rsp_data}, 36'd0);
    chk("rst_bus", {address, chipselect, write, read, writedata}, 36'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {35'd0, cmd_ready}, 36'd1);

    // ---- compare "abca" vs "abcd": done on third poll, result 0 ----
    s_need = 3; s_res = 32'h0000_0000;
    mark = bus_n;
    start_cmd(3'd0, 3'd0, 32'h6162_6361, 32'h6162_6364);
    chk("busy_not_ready", {35'd0, cmd_ready}, 36'd0);
    wait_rsp(lat);
    chk("cmp_data", {4'd0, rsp_data}, 36'h0_0000_0000);
    exp1[0] = bw(3'd0, 32'h6162_6361);
    exp1[1] = bw(3'd1, 32'h6162_6364);
    exp1[2] = bw(3'd2, 32'h0000_0002);
    exp1[3] = br(3'd2);
    exp1[4] = br(3'd2);
    exp1[5] = br(3'd2);
    exp1[6] = br(3'd3);
    exp1[7] = bw(3'd2, 32'h0000_0000);
    chk("cmp_bus_count", 36'(bus_n - mark), 36'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("cmp_bus_%0d", i), bus_log[mark + i], exp1[i]);
    chk("slave_a", {4'd0, s_a}, {4'd0, 32'h6162_6361});
    chk("slave_b", {4'd0, s_b}, {4'd0, 32'h6162_6364});
    tick(); tick(); tick();
    chk("cmp_valid_held", {35'd0, rsp_valid}, 36'd1);
    finish_rsp();
    chk("cmp_valid_drop", {35'd0, rsp_valid}, 36'd0);

    // ---- compare equal: first-poll done, 9-cycle latency, length field ----
    s_need = 1; s_res = 32'h0000_0001;
    mark = bus_n;
    start_cmd(3'd0, 3'd4, 32'h6162_6364, 32'h6162_6364);
    wait_rsp(lat);
    chk("eq_latency", 36'(lat), 36'd9);
    chk("eq_data", {4'd0, rsp_data}, 36'h0_0000_0001);
    chk("eq_go_word", bus_log[mark + 2], bw(3'd2, 32'h0000_0082));
    chk("eq_clr_word", bus_log[mark + 5], bw(3'd2, 32'h0000_0080));
    finish_rsp();

    // ---- to-upper then to-lower back to back ----
    s_need = 1; s_res = 32'h4142_0000;
    mark = bus_n;
    start_cmd(3'd1, 3'd0, 32'h4162_0000, 32'h0);
    wait_rsp(lat);
    chk("up_data", {4'd0, rsp_data}, {4'd0, 32'h4142_0000});
    chk("up_go_word", bus_log[mark + 2], bw(3'd2, 32'h0000_0006));
    cmd_index = 3'd2; cmd_length = 3'd0; cmd_a = 32'h4142_4344; cmd_b = 32'h0;
    cmd_valid = 1'b1;
    s_res = 32'h6162_6364;
    tick();
    chk("b2b_ready_low", {35'd0, cmd_ready}, 36'd0);
    finish_rsp();
    chk("b2b_rsp_done", {35'd0, rsp_valid}, 36'd0);
    chk("b2b_ready_high", {35'd0, cmd_ready}, 36'd1);
    mark = bus_n;
    start_cmd(3'd2, 3'd0, 32'h4142_4344, 32'h0);
    wait_rsp(lat);
    chk("low_data", {4'd0, rsp_data}, {4'd0, 32'h6162_6364});
    chk("low_go_word", bus_log[mark + 2], bw(3'd2, 32'h0000_000A));
    finish_rsp();

    // ---- response backpressure ----
    s_need = 2; s_res = 32'hCAFE_0001;
    start_cmd(3'd3, 3'd2, 32'h1111_2222, 32'h3333_4444);
    wait_rsp(lat);
    held = rsp_data;
    chk("bp_data", {4'd0, held}, {4'd0, 32'hCAFE_0001});
    bad_v = 0; bad_d = 0; bad_b = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!rsp_valid) bad_v++;
      if (rsp_data !== held) bad_d++;
      if (chipselect || write || read) bad_b++;
      if (cmd_ready) bad_r++;
    end
    chk("bp_valid_stable", 36'(bad_v), 36'd0);
    chk("bp_data_stable", 36'(bad_d), 36'd0);
    chk("bp_bus_quiet", 36'(bad_b), 36'd0);
    chk("bp_not_ready", 36'(bad_r), 36'd0);
    finish_rsp();
    chk("bp_idle_ready", {35'd0, cmd_ready}, 36'd1);

    // ---- reset while waiting on a poll ----
    s_need = 1000000;
    start_cmd(3'd0, 3'd0, 32'h0102_0304, 32'h0506_0708);
    tick(); tick(); tick(); tick();   // WR_B, WR_GO, POLL_RD, POLL_WAIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_bus", {address, chipselect, write, read, writedata}, 36'd0);
    chk("midrst_rsp", {34'd0, rsp_valid, cmd_ready}, 36'd0);
    tick();
    chk("midrst_ready", {35'd0, cmd_ready}, 36'd1);
    s_need = 1; s_res = 32'h0000_1234;
    start_cmd(3'd0, 3'd0, 32'h6162_6364, 32'h6162_6364);
    wait_rsp(lat);
    chk("midrst_latency", 36'(lat), 36'd9);
    chk("midrst_data", {4'd0, rsp_data}, 36'h0_0000_1234);
    finish_rsp();

    // ---- slave never finishes ----
    s_need = 1000000;
    mark = bus_n;
    start_cmd(3'd0, 3'd0, 32'h7777_7777, 32'h8888_8888);
`ifdef STRING_MASTER_TIMEOUT_EN
    wait_rsp(lat);
    chk("tmo_data", {4'd0, rsp_data}, {4'd0, 32'hFFFF_FFFF});
    chk("tmo_error", {35'd0, rsp_error}, 36'd1);
    chk("tmo_clr_go", bus_log[bus_n - 1], bw(3'd2, 32'h0000_0000));
    finish_rsp();
    s_need = 1; s_res = 32'h0000_0005;
    start_cmd(3'd0, 3'd0, 32'h6162_6364, 32'h6162_6364);
    chk("tmo_err_clear", {35'd0, rsp_error}, 36'd0);
    wait_rsp(lat);
    chk("tmo_next_data", {4'd0, rsp_data}, 36'h0_0000_0005);
    finish_rsp();
`else
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("poll_no_rsp", 36'(seen), 36'd0);
    chk("poll_continues", {35'd0, (s_polls - s_base) >= 40}, 36'd1);
    chk("poll_no_error", {35'd0, rsp_error}, 36'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    chk("cs_matches_strobes", 36'(cs_bad), 36'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
